// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU function codes, write-back select encoding and
// opcode classification helpers used by the ALU and the EX/MEM stage.
package mips_pkg;

    localparam logic [5:0] FN_BLEZ  = 6'b000111;
    localparam logic [5:0] FN_BGTZ  = 6'b001000;
    localparam logic [5:0] FN_BEQ   = 6'b001001;
    localparam logic [5:0] FN_BNE   = 6'b001010;
    localparam logic [5:0] FN_BGEZ  = 6'b001011;
    localparam logic [5:0] FN_BLTZ  = 6'b001100;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_HI   = 2'd1,
        SEL_LO   = 2'd2,
        SEL_LINK = 2'd3
    } out_sel_e;

    function automatic logic is_branch(input logic [5:0] fn);
        return (fn == FN_BLEZ) || (fn == FN_BGTZ) || (fn == FN_BEQ) ||
               (fn == FN_BNE)  || (fn == FN_BGEZ) || (fn == FN_BLTZ);
    endfunction

    function automatic logic is_mult(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Handshake bundles around the EX/MEM stage: the EX-side request bus and the
// MEM-side result bus, each with master (driver) and slave (receiver) views.
interface ex_bus_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [5:0]            op_sel;
    logic [WIDTH-1:0]      result_lo;
    logic [WIDTH-1:0]      result_hi;
    logic                  branch_taken;
    logic [1:0]            out_sel;
    logic [WIDTH-1:0]      pc_plus4;
    logic [WIDTH-1:0]      branch_target;
    logic [WIDTH-1:0]      store_data;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;

    modport master (
        output ex_valid, op_sel, result_lo, result_hi, branch_taken, out_sel,
               pc_plus4, branch_target, store_data, dest, reg_write, mem_read, mem_write,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, op_sel, result_lo, result_hi, branch_taken, out_sel,
               pc_plus4, branch_target, store_data, dest, reg_write, mem_read, mem_write,
        output ex_ready
    );
endinterface

interface mem_bus_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [WIDTH-1:0]      mem_alu_out;
    logic [WIDTH-1:0]      mem_store_data;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic                  mem_mem_write;

    modport master (
        output mem_valid, mem_alu_out, mem_store_data, mem_dest,
               mem_reg_write, mem_mem_read, mem_mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_alu_out, mem_store_data, mem_dest,
               mem_reg_write, mem_mem_read, mem_mem_write,
        output mem_ready
    );
endinterface

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair, written together by multiply instructions.
module hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] hi_d,
    input  logic [WIDTH-1:0] lo_d,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results under valid/ready, owns HI/LO,
// pulses a fetch redirect for taken branches and squashes the wrong-path follower.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_bus_if.slave           ex,
    mem_bus_if.master         mem,
    output logic              redirect_valid,
    output logic [WIDTH-1:0]  redirect_pc,
    output logic [WIDTH-1:0]  hi_out,
    output logic [WIDTH-1:0]  lo_out,
    output logic              halted
);

    logic                  mem_valid_q;
    logic [WIDTH-1:0]      alu_out_q;
    logic [WIDTH-1:0]      store_data_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  squash_pending;

    logic                  accept;
    logic                  take;
    logic                  take_halt;
    logic                  take_mult;
    logic                  take_redirect;
    logic [WIDTH-1:0]      alu_sel;

    assign ex.ex_ready = !halted && (!mem_valid_q || mem.mem_ready);
    assign accept      = ex.ex_valid && ex.ex_ready;

    // An accept while a squash is pending consumes the wrong-path instruction silently.
    assign take          = accept && !squash_pending;
    assign take_halt     = take && (ex.op_sel == FN_HALT);
    assign take_mult     = take && is_mult(ex.op_sel);
    assign take_redirect = take && is_branch(ex.op_sel) && ex.branch_taken;

    // HI/LO select reads the register outputs, i.e. the value before this accept's update.
    always_comb begin
        alu_sel = ex.result_lo;
        case (out_sel_e'(ex.out_sel))
            SEL_HI:   alu_sel = hi_out;
            SEL_LO:   alu_sel = lo_out;
            SEL_LINK: alu_sel = ex.pc_plus4 + WIDTH'(4);
            default:  alu_sel = ex.result_lo;
        endcase
    end

    hilo_reg #(.WIDTH(WIDTH)) u_hilo (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (take_mult),
        .hi_d  (ex.result_hi),
        .lo_d  (ex.result_lo),
        .hi_q  (hi_out),
        .lo_q  (lo_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else if (take) begin
            mem_valid_q  <= 1'b1;
            alu_out_q    <= alu_sel;
            store_data_q <= ex.store_data;
            dest_q       <= ex.dest;
            reg_write_q  <= ex.reg_write && !is_mult(ex.op_sel) && (ex.op_sel != FN_HALT);
            mem_read_q   <= ex.mem_read  && (ex.op_sel != FN_HALT);
            mem_write_q  <= ex.mem_write && (ex.op_sel != FN_HALT);
        end else if (mem_valid_q && mem.mem_ready) begin
            mem_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            squash_pending <= 1'b0;
            halted         <= 1'b0;
        end else begin
            redirect_valid <= take_redirect;
            if (take_redirect) begin
                redirect_pc    <= ex.branch_target;
                squash_pending <= 1'b1;
            end else if (accept) begin
                squash_pending <= 1'b0;
            end
            if (take_halt) begin
                halted <= 1'b1;
            end
        end
    end

    assign mem.mem_valid      = mem_valid_q;
    assign mem.mem_alu_out    = alu_out_q;
    assign mem.mem_store_data = store_data_q;
    assign mem.mem_dest       = dest_q;
    assign mem.mem_reg_write  = reg_write_q;
    assign mem.mem_mem_read   = mem_read_q;
    assign mem.mem_mem_write  = mem_write_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_ex_mem_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic halted;

    int errors;
    int checks;

    ex_bus_if  #(.WIDTH(32), .REG_ADDR_W(5)) ex_bus ();
    mem_bus_if #(.WIDTH(32), .REG_ADDR_W(5)) mem_bus ();

    ex_mem_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex             (ex_bus),
        .mem            (mem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hi_out         (hi_out),
        .lo_out         (lo_out),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        m_valid, m_rw, m_mr, m_mw, m_redir, m_halt, m_sq;
    logic [31:0] m_alu, m_sd, m_rpc, m_hi, m_lo;
    logic [4:0]  m_dest;
    logic        m_ready;
    logic        op_is_mult, op_is_halt, op_is_br;

    assign m_ready    = !m_halt && (!m_valid || mem_bus.mem_ready);
    assign op_is_mult = (ex_bus.op_sel == 6'h18) || (ex_bus.op_sel == 6'h19);
    assign op_is_halt = (ex_bus.op_sel == 6'h3F);
    assign op_is_br   = (ex_bus.op_sel >= 6'h07) && (ex_bus.op_sel <= 6'h0C);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_redir <= 0;
            m_halt <= 0; m_sq <= 0; m_alu <= 0; m_sd <= 0; m_rpc <= 0;
            m_hi <= 0; m_lo <= 0; m_dest <= 0;
        end else begin
            m_redir <= 0;
            if (ex_bus.ex_valid && m_ready) begin
                if (m_sq) begin
                    m_sq    <= 0;
                    m_valid <= 0;
                end else begin
                    m_valid <= 1;
                    m_dest  <= ex_bus.dest;
                    m_sd    <= ex_bus.store_data;
                    if (ex_bus.out_sel == 2'd0)      m_alu <= ex_bus.result_lo;
                    else if (ex_bus.out_sel == 2'd1) m_alu <= m_hi;
                    else if (ex_bus.out_sel == 2'd2) m_alu <= m_lo;
                    else                             m_alu <= ex_bus.pc_plus4 + 32'd4;
                    m_rw <= ex_bus.reg_write && !op_is_mult && !op_is_halt;
                    m_mr <= ex_bus.mem_read && !op_is_halt;
                    m_mw <= ex_bus.mem_write && !op_is_halt;
                    if (op_is_mult) begin
                        m_hi <= ex_bus.result_hi;
                        m_lo <= ex_bus.result_lo;
                    end
                    if (op_is_halt) m_halt <= 1;
                    if (op_is_br && ex_bus.branch_taken) begin
                        m_redir <= 1;
                        m_rpc   <= ex_bus.branch_target;
                        m_sq    <= 1;
                    end
                end
            end else if (m_valid && mem_bus.mem_ready) begin
                m_valid <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("ex_ready", 32'(ex_bus.ex_valid ? ex_bus.ex_ready : ex_bus.ex_ready), 32'(m_ready));
        check("mem_valid", 32'(mem_bus.mem_valid), 32'(m_valid));
        check("mem_alu_out", mem_bus.mem_alu_out, m_alu);
        check("mem_store_data", mem_bus.mem_store_data, m_sd);
        check("mem_dest", 32'(mem_bus.mem_dest), 32'(m_dest));
        check("mem_ctrl", {29'd0, mem_bus.mem_reg_write, mem_bus.mem_mem_read, mem_bus.mem_mem_write},
              {29'd0, m_rw, m_mr, m_mw});
        check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        check("redirect_pc", redirect_pc, m_rpc);
        check("hi_out", hi_out, m_hi);
        check("lo_out", lo_out, m_lo);
        check("halted", 32'(halted), 32'(m_halt));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] rlo, input logic [31:0] rhi,
                         input logic bt, input logic [1:0] sel, input logic [31:0] pc4,
                         input logic [31:0] tgt, input logic [31:0] sd, input logic [4:0] dst,
                         input logic rw, input logic mr, input logic mw);
        ex_bus.ex_valid      = 1'b1;
        ex_bus.op_sel        = op;
        ex_bus.result_lo     = rlo;
        ex_bus.result_hi     = rhi;
        ex_bus.branch_taken  = bt;
        ex_bus.out_sel       = sel;
        ex_bus.pc_plus4      = pc4;
        ex_bus.branch_target = tgt;
        ex_bus.store_data    = sd;
        ex_bus.dest          = dst;
        ex_bus.reg_write     = rw;
        ex_bus.mem_read      = mr;
        ex_bus.mem_write     = mw;
    endtask

    task automatic idle();
        ex_bus.ex_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        issue(6'h00, 0, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        idle();
        mem_bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("lit reset ex_ready", 32'(ex_bus.ex_ready), 32'd1);
        check("lit reset mem_valid", 32'(mem_bus.mem_valid), 32'd0);

        // MULTU 0xFFFFFFFF x 2, then MFHI back-to-back
        issue(FN_MULTU, 32'hFFFF_FFFE, 32'h1, 0, 2'd0, 32'h10, 0, 0, 5'd3, 1, 0, 0);
        step();
        check("lit multu reg_write", 32'(mem_bus.mem_reg_write), 32'd0);
        check("lit multu hi", hi_out, 32'h1);
        check("lit multu lo", lo_out, 32'hFFFF_FFFE);
        issue(FN_MFHI, 32'h0, 32'h0, 0, 2'd1, 32'h14, 0, 0, 5'd4, 1, 0, 0);
        step();
        check("lit mfhi alu", mem_bus.mem_alu_out, 32'h1);
        check("lit mfhi reg_write", 32'(mem_bus.mem_reg_write), 32'd1);

        // Taken BEQ: redirect pulse, follower squashed, next passes
        issue(FN_BEQ, 0, 0, 1, 2'd0, 32'h20, 32'h40, 0, 5'd0, 0, 0, 0);
        step();
        check("lit beq redirect_valid", 32'(redirect_valid), 32'd1);
        check("lit beq redirect_pc", redirect_pc, 32'h40);
        issue(FN_ADDU, 32'd5, 0, 0, 2'd0, 32'h24, 0, 0, 5'd5, 1, 0, 0);
        step();
        check("lit squash redirect_valid", 32'(redirect_valid), 32'd0);
        check("lit squash mem_valid", 32'(mem_bus.mem_valid), 32'd0);
        issue(FN_ADDU, 32'd7, 0, 0, 2'd0, 32'h44, 0, 0, 5'd6, 1, 0, 0);
        step();
        check("lit after squash valid", 32'(mem_bus.mem_valid), 32'd1);
        check("lit after squash alu", mem_bus.mem_alu_out, 32'd7);

        // Taken branch followed by taken branch: second is squashed, no second redirect
        issue(FN_BEQ, 0, 0, 1, 2'd0, 32'h48, 32'h40, 0, 5'd0, 0, 0, 0);
        step();
        issue(FN_BNE, 0, 0, 1, 2'd0, 32'h4C, 32'h80, 0, 5'd0, 0, 0, 0);
        step();
        check("lit br-br redirect", 32'(redirect_valid), 32'd0);
        check("lit br-br redirect_pc", redirect_pc, 32'h40);
        issue(FN_ADDU, 32'd9, 0, 0, 2'd0, 32'h44, 0, 0, 5'd9, 1, 0, 0);
        step();
        check("lit br-br follower alu", mem_bus.mem_alu_out, 32'd9);

        // Not-taken branch then ADDU: no redirect, no squash
        issue(FN_BNE, 0, 0, 0, 2'd0, 32'h48, 32'h90, 0, 5'd0, 0, 0, 0);
        step();
        check("lit nt redirect", 32'(redirect_valid), 32'd0);
        issue(FN_ADDU, 32'hAB, 0, 0, 2'd0, 32'h4C, 0, 32'h55, 5'd10, 0, 0, 1);
        step();
        check("lit nt follower alu", mem_bus.mem_alu_out, 32'hAB);
        check("lit nt follower mem_write", 32'(mem_bus.mem_mem_write), 32'd1);

        // Link select
        issue(FN_ADDU, 32'h0, 0, 0, 2'd3, 32'h100, 0, 0, 5'd31, 1, 0, 0);
        step();
        check("lit link alu", mem_bus.mem_alu_out, 32'h104);

        // Stall: hold mem_ready low for 3 cycles with a new instruction waiting
        issue(FN_ADDU, 32'h11, 0, 0, 2'd0, 32'h104, 0, 0, 5'd7, 1, 0, 0);
        step();
        mem_bus.mem_ready = 1'b0;
        issue(FN_ADDU, 32'h22, 0, 0, 2'd0, 32'h108, 0, 0, 5'd8, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lit stall ex_ready", 32'(ex_bus.ex_ready), 32'd0);
            check("lit stall alu", mem_bus.mem_alu_out, 32'h11);
        end
        mem_bus.mem_ready = 1'b1;
        step();
        check("lit release alu", mem_bus.mem_alu_out, 32'h22);
        check("lit release dest", 32'(mem_bus.mem_dest), 32'd8);
        idle();
        step();
        check("lit drain valid", 32'(mem_bus.mem_valid), 32'd0);
        check("lit drain alu hold", mem_bus.mem_alu_out, 32'h22);

        // Asynchronous reset mid-stall after a MULT
        issue(FN_MULT, 32'h1234, 32'h5678, 0, 2'd0, 32'h200, 0, 0, 5'd2, 1, 0, 0);
        step();
        mem_bus.mem_ready = 1'b0;
        issue(FN_ADDU, 32'h33, 0, 0, 2'd0, 32'h204, 0, 0, 5'd3, 1, 0, 0);
        step();
        check("lit pre-reset hi", hi_out, 32'h5678);
        #2 rst_n = 1'b0;
        #1;
        check("lit async mem_valid", 32'(mem_bus.mem_valid), 32'd0);
        check("lit async alu", mem_bus.mem_alu_out, 32'd0);
        check("lit async hi", hi_out, 32'd0);
        check("lit async lo", lo_out, 32'd0);
        check("lit async halted", 32'(halted), 32'd0);
        idle();
        mem_bus.mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("lit post-reset ex_ready", 32'(ex_bus.ex_ready), 32'd1);

        // HALT, then keep presenting instructions
        issue(FN_HALT, 32'h77, 0, 0, 2'd0, 32'h300, 0, 0, 5'd12, 1, 1, 1);
        step();
        check("lit halt mem_valid", 32'(mem_bus.mem_valid), 32'd1);
        check("lit halt writes", {29'd0, mem_bus.mem_reg_write, mem_bus.mem_mem_read, mem_bus.mem_mem_write}, 32'd0);
        check("lit halt halted", 32'(halted), 32'd1);
        check("lit halt ex_ready", 32'(ex_bus.ex_ready), 32'd0);
        issue(FN_ADDU, 32'h88, 0, 0, 2'd0, 32'h304, 0, 0, 5'd13, 1, 0, 0);
        repeat (3) step();
        check("lit halted ex_ready", 32'(ex_bus.ex_ready), 32'd0);
        check("lit halted mem_valid", 32'(mem_bus.mem_valid), 32'd0);
        check("lit halted alu hold", mem_bus.mem_alu_out, 32'h77);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage that registers the ALU outputs, keeps the architectural HI/LO pair, and resolves branches. It sits directly downstream of the combinational ALU. It captures Result, Result_H and Branch_Taken together with the instruction's control bits under a valid/ready handshake with the memory stage. It also issues a one-cycle fetch redirect for taken branches and squashes the wrong-path instruction that follows.

## Interface
- WIDTH, 32, datapath width
- REG_ADDR_W, 5, register-file index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  stage accepts this cycle
- op_sel  in  6  ALU function code of the EX instruction
- result_lo  in  WIDTH  ALU Result
- result_hi  in  WIDTH  ALU Result_H
- branch_taken  in  1  ALU Branch_Taken
- out_sel  in  2  write-back select: 0 ALU, 1 HI, 2 LO, 3 link
- pc_plus4  in  WIDTH  PC+4 of the EX instruction
- branch_target  in  WIDTH  computed branch target
- store_data  in  WIDTH  rt value for stores
- dest  in  REG_ADDR_W  destination register
- reg_write, mem_read, mem_write  in  1 each  control bits
- mem_valid  out  1  MEM-side output valid
- mem_ready  in  1  MEM accepts
- mem_alu_out  out  WIDTH  selected result
- mem_store_data  out  WIDTH  registered store_data
- mem_dest  out  REG_ADDR_W  registered dest
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control bits
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  WIDTH  redirect target
- hi_out, lo_out  out  WIDTH  architectural HI/LO
- halted  out  1  sticky halt flag

## Operation
- Accept condition: ex_valid && ex_ready.
- ex_ready = !halted && (!mem_valid || mem_ready).
- On accept of a non-squashed instruction:
  - Output registers load: mem_valid=1, dest, control bits, store_data.
  - mem_alu_out is chosen by out_sel:
    - 0: result_lo
    - 1: hi_out (pre-update value)
    - 2: lo_out (pre-update value)
    - 3: pc_plus4+4
- MULT (011000) or MULTU (011001) accepted: HI←result_hi, LO←result_lo.
  - mem_reg_write is forced to 0 for these ops.
- Branch ops are BLEZ 000111, BGTZ 001000, BEQ 001001, BNE 001010, BGEZ 001011, BLTZ 001100.
  - Accepted branch with branch_taken=1: next cycle redirect_valid=1 and redirect_pc=branch_target; squash_pending←1.
  - Accepted branch not taken: no redirect.
- Squash: the next accepted instruction while squash_pending=1 is consumed with no effects.
  - No mem_valid, no HI/LO write, no halt, no redirect.
  - squash_pending←0.
- HALT (111111) accepted and not squashed: halted←1 and passes to MEM as valid with all write controls forced 0. Thereafter ex_ready=0 until reset.
- When mem_valid && mem_ready and nothing new is accepted: mem_valid←0; data registers hold their values.
- Stall: while mem_valid && !mem_ready, all outputs hold; HI/LO and squash_pending hold.

## Timing
- Latency: accept at edge N → mem_valid and data visible after edge N; redirect_valid high for exactly the cycle after edge N.
- Back-to-back: a MULT accepted at N followed by an MFHI-style out_sel=1 accepted at N+1 reads the new HI (HI updates at N).
- A redirect pulse is never extended by a MEM stall. The squash applies to the next accept, whenever it occurs.
- A taken branch is followed by a branch: the second branch is squashed, and no second redirect is issued.
- Reset (any time, including mid-stall): all outputs 0; HI=LO=0; squash_pending=0; halted=0. ex_ready=1 after release.

## Structure
- Shared package mips_pkg:
  - function-code localparams (shared with the ALU)
  - out_sel enum: SEL_ALU, SEL_HI, SEL_LO, SEL_LINK
  - is_branch and is_mult helper functions
- Sub-module hilo_reg: HI/LO pair with write enable and async active-low reset.
- Everything else is in ex_mem_stage: output register, squash_pending, halted, and the redirect flop.

## Test plan
- MULTU 0xFFFFFFFF×2 (result_hi=1, result_lo=0xFFFFFFFE), then out_sel=1 next cycle → hi_out=1, lo_out=0xFFFFFFFE; second mem_alu_out=1, first mem_reg_write=0.
- Accept BEQ with branch_taken=1 and branch_target=0x40 → redirect_valid=1 with redirect_pc=0x40 for one cycle; next ADDU (result_lo=5) is squashed, giving no mem_valid; the following ADDU passes.
- Hold mem_ready=0 for 3 cycles with ex_valid=1 → ex_ready=0 and outputs stable; on release, the held instruction drains and the new one is accepted in the same cycle.
- Accept HALT, then keep ex_valid=1 → one valid MEM beat with writes 0, halted=1, ex_ready stays 0.
- Assert rst_n=0 mid-stall after a MULT → all outputs, hi_out, lo_out and halted read 0 immediately (asynchronous); ex_ready=1 after release.
- out_sel=3 with pc_plus4=0x100 → mem_alu_out=0x104.
